popcount_expand_int64: RTL and testbench

- Inverse of the 64-bit popcount reduction tree: takes a 7-bit count N and produces a 64-bit thermometer mask with bits [N-1:0] set and all others clear.
- Builds the mask over several cycles, CHUNK bits per cycle, mirroring the partial-word staging used in the bit-serial benchmarks.
- Sits downstream of popcount results, producing fill and predicate masks for the PIM benchmark flows.
- Valid/ready handshake on both the input and output sides.

---
 rtl/popcount_expand_int64.sv | 117 +++++++++++
 tb/tb_popcount_expand_int64.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/popcount_expand_int64.sv
// Count-to-thermometer expander: N -> mask with bits [N-1:0] set, built CHUNK bits per cycle; optional self-check via POPCOUNT_EXPAND_SELFCHECK_EN.
// Latency: out_valid rises NCHUNK edges after the accepting edge; one result per NCHUNK+2 cycles.
// Backpressure: in_ready only in IDLE; result (Y, sat, chk_err) held in DONE until out_ready.
module popcount_expand_int64 #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             sat,
  output logic             chk_err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] y_nxt;
  logic             accept;
  logic             release_out;
  logic             last_chunk;
  logic             over;

  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign last_chunk  = (idx == LAST_IDX);
  assign over        = (int'(in_cnt) > WIDTH);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = FILL;
      FILL:    if (last_chunk)  state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Only the chunk selected by idx changes; the rest of the mask carries over.
  always_comb begin
    y_nxt = Y;
    for (int b = 0; b < WIDTH; b++) begin
      if ((b / CHUNK) == int'(idx)) y_nxt[b] = (b < int'(cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y   <= '0;
      sat <= 1'b0;
      cnt <= '0;
      idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= over ? CNT_W'(WIDTH) : in_cnt;
            sat <= over;
            Y   <= '0;
            idx <= '0;
          end
        end
        FILL: begin
          Y   <= y_nxt;
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef POPCOUNT_EXPAND_SELFCHECK_EN
  logic [CNT_W-1:0] pc_nxt;

  // Popcount of the completed mask is taken from y_nxt so the check costs no extra cycle.
  always_comb begin
    pc_nxt = '0;
    for (int b = 0; b < WIDTH; b++) pc_nxt = pc_nxt + CNT_W'(y_nxt[b]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                          chk_err <= 1'b0;
    else if (state == FILL && last_chunk) chk_err <= (pc_nxt != cnt);
    else if (release_out)                 chk_err <= 1'b0;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_expand_int64.sv
// Bench for popcount_expand_int64: directed scenarios plus random counts against an arithmetic mask model.
module tb_popcount_expand_int64;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] y;
  logic        sat;
  logic        chk_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int gap = 0;

  popcount_expand_int64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cnt    (in_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (y),
    .sat       (sat),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_mask(input int n);
    if (n >= 64) return {64{1'b1}};
    return (64'd1 << n) - 64'd1;
  endfunction

  // One complete transaction; caller is positioned just after an edge with the block idle.
  task automatic run(input int n, input int hold, input bit poke);
    logic [63:0] exp_y;
    int lat;
    exp_y = model_mask(n);
    in_cnt   = 7'(n);
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    in_cnt   = 7'($urandom);
    gap      = cyc - last_acc;
    last_acc = cyc;
    check("busy_in_ready", in_ready, 0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      in_valid = poke;
      step;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, 8);
    check("y", y, exp_y);
    check("sat", sat, (n > 64));
    check("chk_err", chk_err, 0);
    check("done_in_ready", in_ready, 0);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid = poke;
      in_cnt   = 7'($urandom);
      step;
      check("hold_valid", out_valid, 1);
      check("hold_y", y, exp_y);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cnt    = '0;
    out_ready = 1'b1;
    step;
    step;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 64'h0);
    check("rst_sat", sat, 0);
    check("rst_chk_err", chk_err, 0);
    rst_n = 1'b1;
    step;

    run(0, 0, 1'b0);
    run(37, 0, 1'b0);
    check("y37_const", y, 64'h0000_001F_FFFF_FFFF);
    run(64, 0, 1'b0);
    run(100, 0, 1'b0);
    run(9, 5, 1'b1);
    check("y9_const", y, 64'h1FF);
    run(1, 0, 1'b0);
    run(63, 0, 1'b0);
    check("b2b_gap", gap, 10);
    check("y63_const", y, 64'h7FFF_FFFF_FFFF_FFFF);

    // Reset during the 4th FILL cycle of a 40-count request.
    in_cnt   = 7'd40;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    step;
    step;
    rst_n = 1'b0;
    step;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y", y, 64'h0);
    check("midrst_sat", sat, 0);
    rst_n = 1'b1;
    run(3, 0, 1'b0);
    check("y3_const", y, 64'h7);

    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(0, 127);
      run(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
